// File: rtl/reg_scoreboard_pkg.sv
// Shared scoreboard definitions: sizing, register index types and GPR names.
package reg_scoreboard_pkg;

  localparam int NREG = 32;  // tracked architectural registers
  localparam int CNTW = 2;   // pending-writer counter width
  localparam int IDXW = 5;   // register index width

  typedef logic [IDXW-1:0] reg_idx_t;
  typedef reg_idx_t [2:0]  src_arr_t;  // three packed source indices
  typedef reg_idx_t [1:0]  dst_arr_t;  // two packed destination / writeback indices

  // x86-64 GPR encodings
  localparam reg_idx_t RAX = 5'd0;
  localparam reg_idx_t RCX = 5'd1;
  localparam reg_idx_t RDX = 5'd2;
  localparam reg_idx_t RBX = 5'd3;
  localparam reg_idx_t RSP = 5'd4;
  localparam reg_idx_t RBP = 5'd5;
  localparam reg_idx_t RSI = 5'd6;
  localparam reg_idx_t RDI = 5'd7;
  localparam reg_idx_t R8  = 5'd8;
  localparam reg_idx_t R9  = 5'd9;

  // Number of valid lanes (0..2) of a two-lane index bundle naming idx.
  function automatic logic [1:0] hit_count(input logic [1:0] v, input dst_arr_t r,
                                           input reg_idx_t idx);
    hit_count = {1'b0, v[0] && (r[0] == idx)} + {1'b0, v[1] && (r[1] == idx)};
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / status bundle between the decoder and the scoreboard.
//
// Handshake: a uop issues (iss_fire) in a cycle where iss_valid and iss_ready
// are both high at the rising edge. iss_ready is combinational from registered
// counter state plus this cycle's flush/reset and the uop's own src/dst
// fields; it never depends on same-cycle writebacks. iss_valid and the uop
// fields may change freely while iss_ready is low. Writebacks (wb_v) have no
// back-pressure and are always consumed.
interface reg_scoreboard_if #(parameter int NREG = reg_scoreboard_pkg::NREG);
  import reg_scoreboard_pkg::*;

  logic            iss_valid;
  logic [2:0]      iss_src_v;
  src_arr_t        iss_src_r;
  logic [1:0]      iss_dst_v;
  dst_arr_t        iss_dst_r;
  logic            iss_ready;
  logic [1:0]      wb_v;
  dst_arr_t        wb_r;
  logic            flush;
  logic [NREG-1:0] busy;
  logic [6:0]      pending_cnt;
  logic            err_underflow;
  logic [31:0]     stall_cycles;

  modport master (
    output iss_valid, iss_src_v, iss_src_r, iss_dst_v, iss_dst_r, wb_v, wb_r, flush,
    input  iss_ready, busy, pending_cnt, err_underflow, stall_cycles
  );

  modport slave (
    input  iss_valid, iss_src_v, iss_src_r, iss_dst_v, iss_dst_r, wb_v, wb_r, flush,
    output iss_ready, busy, pending_cnt, err_underflow, stall_cycles
  );

endinterface

// File: rtl/reg_scoreboard_counter.sv
// Per-register pending-writer counter: net up/down update, clamp at 0 with an
// underflow event, saturate at max, flush clears.
module sb_counter #(
  parameter int CNTW = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic [1:0]      i_inc,
  input  logic [1:0]      i_dec,
  output logic [CNTW-1:0] o_cnt,
  output logic [CNTW-1:0] o_cnt_next,
  output logic            o_uflow
);
  localparam int SW = CNTW + 2;
  localparam logic signed [SW-1:0] MAXV = SW'((1 << CNTW) - 1);

  logic [CNTW-1:0]        r_cnt;
  logic signed [SW-1:0]   w_sum;
  logic [CNTW-1:0]        w_next;
  logic                   w_uflow;

  // Net change for the cycle; flush wins and suppresses the underflow event.
  always_comb begin
    w_sum   = $signed({2'b00, r_cnt}) + $signed({{CNTW{1'b0}}, i_inc})
            - $signed({{CNTW{1'b0}}, i_dec});
    w_uflow = 1'b0;
    if (i_flush) begin
      w_next = '0;
    end else if (w_sum < 0) begin
      w_next  = '0;
      w_uflow = 1'b1;
    end else if (w_sum > MAXV) begin
      w_next = '1;
    end else begin
      w_next = w_sum[CNTW-1:0];
    end
  end

  // Counter state.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_cnt <= '0;
    else         r_cnt <= w_next;
  end

  assign o_cnt      = r_cnt;
  assign o_cnt_next = w_next;
  assign o_uflow    = w_uflow;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writers per register, gates issue on
// RAW hazards and counter saturation, and reports busy/pending/error/stall.
module reg_scoreboard #(
  parameter int NREG = reg_scoreboard_pkg::NREG,
  parameter int CNTW = reg_scoreboard_pkg::CNTW
) (
  input logic             clk,
  input logic             reset,
  reg_scoreboard_if.slave sb
);
  import reg_scoreboard_pkg::*;

  localparam int MAXC = (1 << CNTW) - 1;

  logic [CNTW-1:0] w_cnt      [NREG];
  logic [CNTW-1:0] w_cnt_next [NREG];
  logic [NREG-1:0] w_uflow;
  logic [NREG-1:0] w_busy_next;
  logic [6:0]      w_pend_next;
  logic            w_raw;
  logic            w_sat;
  logic            w_ready;
  logic            w_fire;

  logic [NREG-1:0] r_busy;
  logic [6:0]      r_pending;
  logic            r_err;
  logic [31:0]     r_stall;

  // Issue gate from registered counters only; duplicate dsts add twice.
  always_comb begin
    w_raw = 1'b0;
    w_sat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (sb.iss_src_v[i] && (w_cnt[sb.iss_src_r[i]] != '0)) w_raw = 1'b1;
    end
    for (int j = 0; j < 2; j++) begin
      if (sb.iss_dst_v[j] &&
          (int'(w_cnt[sb.iss_dst_r[j]]) +
           int'(hit_count(sb.iss_dst_v, sb.iss_dst_r, sb.iss_dst_r[j])) > MAXC))
        w_sat = 1'b1;
    end
    w_ready = !reset && !sb.flush && !w_raw && !w_sat;
  end

  assign w_fire       = sb.iss_valid && w_ready;
  assign sb.iss_ready = w_ready;

  for (genvar g = 0; g < NREG; g++) begin : g_cnt
    logic [1:0] w_inc;
    logic [1:0] w_dec;
    assign w_inc = w_fire ? hit_count(sb.iss_dst_v, sb.iss_dst_r, reg_idx_t'(g)) : 2'b00;
    assign w_dec = hit_count(sb.wb_v, sb.wb_r, reg_idx_t'(g));

    sb_counter #(.CNTW(CNTW)) u_cnt (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_flush    (sb.flush),
      .i_inc      (w_inc),
      .i_dec      (w_dec),
      .o_cnt      (w_cnt[g]),
      .o_cnt_next (w_cnt_next[g]),
      .o_uflow    (w_uflow[g])
    );
  end

  // Status derived from next-state counters so it lands on the same edge.
  always_comb begin
    w_pend_next = '0;
    for (int i = 0; i < NREG; i++) begin
      w_busy_next[i] = |w_cnt_next[i];
      w_pend_next    = w_pend_next + 7'(w_cnt_next[i]);
    end
  end

  // Status registers, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= '0;
      r_pending <= '0;
      r_err     <= 1'b0;
      r_stall   <= '0;
    end else begin
      r_busy    <= w_busy_next;
      r_pending <= w_pend_next;
      if (|w_uflow) r_err <= 1'b1;
      if (sb.iss_valid && !w_ready && !sb.flush && (r_stall != '1))
        r_stall <= r_stall + 32'd1;
    end
  end

  assign sb.busy          = r_busy;
  assign sb.pending_cnt   = r_pending;
  assign sb.err_underflow = r_err;
  assign sb.stall_cycles  = r_stall;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table-driven bench for reg_scoreboard plus a reset-mid-stall sequence.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_stall;

  reg_scoreboard_if #(.NREG(32)) sb_if ();

  reg_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        valid;
    logic [2:0]  sv;
    logic [14:0] sr;
    logic [1:0]  dv;
    logic [9:0]  dr;
    logic [1:0]  wv;
    logic [9:0]  wr;
    logic        fl;
    logic        e_ready;
    logic [6:0]  e_pend;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  localparam int ROWS = 22;
  vec_t tbl [ROWS];

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [2:0] sv, input logic [14:0] sr,
                       input logic [1:0] dv, input logic [9:0] dr,
                       input logic [1:0] wv, input logic [9:0] wr, input logic fl);
    sb_if.iss_valid = valid;
    sb_if.iss_src_v = sv;
    sb_if.iss_src_r = sr;
    sb_if.iss_dst_v = dv;
    sb_if.iss_dst_r = dr;
    sb_if.wb_v      = wv;
    sb_if.wb_r      = wr;
    sb_if.flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 3'b0, 15'd0, 2'b0, 10'd0, 2'b0, 10'd0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_stall = 0;

    //         valid sv      sr        dv     dr        wv     wr        fl   rdy  pend busy    err
    tbl[0]  = '{1'b1, 3'b000, 15'h0000, 2'b01, 10'h000, 2'b00, 10'h000, 1'b0, 1'b1, 7'd1, 32'h01, 1'b0};
    tbl[1]  = '{1'b1, 3'b100, 15'h00A6, 2'b00, 10'h000, 2'b00, 10'h000, 1'b0, 1'b0, 7'd1, 32'h01, 1'b0};
    tbl[2]  = '{1'b1, 3'b001, 15'h0000, 2'b00, 10'h000, 2'b01, 10'h000, 1'b0, 1'b0, 7'd0, 32'h00, 1'b0};
    tbl[3]  = '{1'b1, 3'b011, 15'h2500, 2'b00, 10'h000, 2'b00, 10'h000, 1'b0, 1'b1, 7'd0, 32'h00, 1'b0};
    tbl[4]  = '{1'b0, 3'b000, 15'h0000, 2'b00, 10'h000, 2'b01, 10'h009, 1'b1, 1'b0, 7'd0, 32'h00, 1'b0};
    tbl[5]  = '{1'b1, 3'b000, 15'h0000, 2'b01, 10'h001, 2'b00, 10'h000, 1'b0, 1'b1, 7'd1, 32'h02, 1'b0};
    tbl[6]  = '{1'b1, 3'b000, 15'h0000, 2'b01, 10'h001, 2'b00, 10'h000, 1'b0, 1'b1, 7'd2, 32'h02, 1'b0};
    tbl[7]  = '{1'b1, 3'b000, 15'h0000, 2'b01, 10'h001, 2'b00, 10'h000, 1'b0, 1'b1, 7'd3, 32'h02, 1'b0};
    tbl[8]  = '{1'b1, 3'b000, 15'h0000, 2'b01, 10'h001, 2'b00, 10'h000, 1'b0, 1'b0, 7'd3, 32'h02, 1'b0};
    tbl[9]  = '{1'b1, 3'b000, 15'h0000, 2'b01, 10'h001, 2'b00, 10'h000, 1'b0, 1'b0, 7'd3, 32'h02, 1'b0};
    tbl[10] = '{1'b0, 3'b000, 15'h0000, 2'b00, 10'h000, 2'b11, 10'h021, 1'b0, 1'b1, 7'd1, 32'h02, 1'b0};
    tbl[11] = '{1'b0, 3'b000, 15'h0000, 2'b00, 10'h000, 2'b01, 10'h001, 1'b0, 1'b1, 7'd0, 32'h00, 1'b0};
    tbl[12] = '{1'b1, 3'b000, 15'h0000, 2'b01, 10'h003, 2'b00, 10'h000, 1'b0, 1'b1, 7'd1, 32'h08, 1'b0};
    tbl[13] = '{1'b1, 3'b000, 15'h0000, 2'b01, 10'h003, 2'b01, 10'h003, 1'b0, 1'b1, 7'd1, 32'h08, 1'b0};
    tbl[14] = '{1'b0, 3'b000, 15'h0000, 2'b00, 10'h000, 2'b01, 10'h003, 1'b0, 1'b1, 7'd0, 32'h00, 1'b0};
    tbl[15] = '{1'b1, 3'b000, 15'h0000, 2'b11, 10'h040, 2'b00, 10'h000, 1'b0, 1'b1, 7'd2, 32'h05, 1'b0};
    tbl[16] = '{1'b1, 3'b000, 15'h0000, 2'b11, 10'h084, 2'b00, 10'h000, 1'b0, 1'b1, 7'd4, 32'h15, 1'b0};
    tbl[17] = '{1'b1, 3'b000, 15'h0000, 2'b11, 10'h084, 2'b00, 10'h000, 1'b0, 1'b0, 7'd4, 32'h15, 1'b0};
    tbl[18] = '{1'b1, 3'b000, 15'h0000, 2'b01, 10'h004, 2'b00, 10'h000, 1'b0, 1'b1, 7'd5, 32'h15, 1'b0};
    tbl[19] = '{1'b0, 3'b000, 15'h0000, 2'b00, 10'h000, 2'b01, 10'h009, 1'b0, 1'b1, 7'd5, 32'h15, 1'b1};
    tbl[20] = '{1'b1, 3'b000, 15'h0000, 2'b01, 10'h001, 2'b00, 10'h000, 1'b1, 1'b0, 7'd0, 32'h00, 1'b1};
    tbl[21] = '{1'b0, 3'b000, 15'h0000, 2'b00, 10'h000, 2'b00, 10'h000, 1'b0, 1'b1, 7'd0, 32'h00, 1'b1};

    // Reset
    reset = 1'b1;
    idle();
    step();
    step();
    check("reset_ready", {31'd0, sb_if.iss_ready}, 32'd0);
    step();
    check("reset_busy", sb_if.busy, 32'd0);
    check("reset_pending", {25'd0, sb_if.pending_cnt}, 32'd0);
    check("reset_err", {31'd0, sb_if.err_underflow}, 32'd0);
    check("reset_stall", sb_if.stall_cycles, 32'd0);
    reset = 1'b0;

    // Table-driven vectors
    for (int k = 0; k < ROWS; k++) begin
      drive(tbl[k].valid, tbl[k].sv, tbl[k].sr, tbl[k].dv, tbl[k].dr,
            tbl[k].wv, tbl[k].wr, tbl[k].fl);
      #1;
      check($sformatf("row%0d_ready", k), {31'd0, sb_if.iss_ready}, {31'd0, tbl[k].e_ready});
      if (tbl[k].valid && !tbl[k].e_ready && !tbl[k].fl) exp_stall++;
      step();
      check($sformatf("row%0d_pending", k), {25'd0, sb_if.pending_cnt}, {25'd0, tbl[k].e_pend});
      check($sformatf("row%0d_busy", k), sb_if.busy, tbl[k].e_busy);
      check($sformatf("row%0d_err", k), {31'd0, sb_if.err_underflow}, {31'd0, tbl[k].e_err});
      check($sformatf("row%0d_stall", k), sb_if.stall_cycles, exp_stall);
    end

    // Saturate RCX, stall for several cycles, then reset in the middle of the stall
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'b0, 15'd0, 2'b01, {5'd0, RCX}, 2'b0, 10'd0, 1'b0);
      #1;
      check($sformatf("sat_fire%0d_ready", k), {31'd0, sb_if.iss_ready}, 32'd1);
      step();
    end
    check("sat_pending", {25'd0, sb_if.pending_cnt}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d_ready", k), {31'd0, sb_if.iss_ready}, 32'd0);
      exp_stall++;
      step();
      check($sformatf("stall%0d_count", k), sb_if.stall_cycles, exp_stall);
    end
    reset = 1'b1;
    #1;
    check("midreset_ready", {31'd0, sb_if.iss_ready}, 32'd0);
    step();
    check("midreset_stall", sb_if.stall_cycles, 32'd0);
    check("midreset_pending", {25'd0, sb_if.pending_cnt}, 32'd0);
    check("midreset_busy", sb_if.busy, 32'd0);
    check("midreset_err", {31'd0, sb_if.err_underflow}, 32'd0);
    reset = 1'b0;
    #1;
    check("postreset_ready", {31'd0, sb_if.iss_ready}, 32'd1);
    step();
    check("postreset_pending", {25'd0, sb_if.pending_cnt}, 32'd1);
    check("postreset_busy", sb_if.busy, 32'h2);
    idle();
    step();

    // Final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning number of tracked architectural registers.
REQ-002 SHALL have parameter CNTW, default 2, meaning width of each per-register pending-writer counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port iss_valid, input, 1, meaning the decoded uop requests issue.
REQ-006 SHALL have ports iss_src_v, input, 3, and iss_src_r, input, 15, meaning three source-register valids and three packed 5-bit indices.
REQ-007 SHALL have ports iss_dst_v, input, 2, and iss_dst_r, input, 10, meaning two destination valids and two packed 5-bit indices (RDX:RAX pairs, stack pointer).
REQ-008 SHALL have port iss_ready, output, 1, meaning combinational issue grant; iss_fire = iss_valid & iss_ready.
REQ-009 SHALL have ports wb_v, input, 2, and wb_r, input, 10, meaning writeback release valids and indices.
REQ-010 SHALL have port flush, input, 1, meaning pipeline squash (branch redirect).
REQ-011 SHALL have port busy, output, NREG, meaning registered flag per register, set when its counter is nonzero.
REQ-012 SHALL have port pending_cnt, output, 7, meaning registered sum of all counters.
REQ-013 SHALL have port err_underflow, output, 1, meaning sticky release-of-idle-register error.
REQ-014 SHALL have port stall_cycles, output, 32, meaning count of cycles with iss_valid & !iss_ready.

Function
REQ-015 SHALL keep one CNTW-bit counter per register; maximum value 2^CNTW-1 (3).
REQ-016 SHALL deassert iss_ready if any valid source has counter nonzero (RAW), from registered state only; a same-cycle wb SHALL NOT bypass.
REQ-017 SHALL deassert iss_ready if any valid destination counter plus its increment this fire exceeds max; duplicate dst indices count as +2.
REQ-018 SHALL permit WAW issue (destination busy but not saturated).
REQ-019 SHALL deassert iss_ready whenever flush is high.
REQ-020 On iss_fire SHALL increment each valid destination counter next cycle; on each valid wb SHALL decrement the named counter; net change per register = increments - decrements in the same cycle.
REQ-021 Duplicate wb indices SHALL decrement by 2.
REQ-022 A decrement taking a counter below 0 SHALL clamp at 0 and set err_underflow, which holds until reset.
REQ-023 flush SHALL zero all counters next cycle, overriding same-cycle fire and wb; wb during flush SHALL NOT set err_underflow.
REQ-024 busy and pending_cnt SHALL reflect counter state with one-cycle latency after the causing edge.
REQ-025 stall_cycles SHALL saturate at 2^32-1 and SHALL NOT count during flush.

Reset
REQ-026 reset SHALL clear all counters, busy, pending_cnt, err_underflow and stall_cycles to 0 on the next edge, overriding flush, fire and wb.
REQ-027 iss_ready SHALL be 0 while reset is high.

Structure
REQ-028 NREG, CNTW, the 5-bit register index typedef and the src/dst packed-array typedefs SHALL live in the shared scoreboard package alongside the GPR index constants.
REQ-029 The per-register up/down saturating counter with clamp-and-flag SHALL be sub-module sb_counter, instantiated NREG times.

Verification
REQ-030 RAW: fire dst=RAX(0); next cycle src=RAX -> iss_ready=0; wb RAX -> iss_ready=1 one cycle later, busy[0]=0.
REQ-031 Saturation: three fires dst=RCX(1), no wb -> pending_cnt=3, fourth with dst RCX -> iss_ready=0, stall_cycles increments each cycle.
REQ-032 Simultaneous: counter RBX(3)=1, fire dst RBX with wb RBX same cycle -> counter stays 1, busy[3]=1.
REQ-033 Dual dst: fire dst0=RAX, dst1=RDX -> busy[0]=busy[2]=1, pending_cnt=2; duplicate dst RSP twice when RSP=2 -> iss_ready=0.
REQ-034 Underflow: wb R9 with counter 0 -> counter 0, err_underflow=1 until reset.
REQ-035 Flush/reset: pending_cnt=5, flush with concurrent fire -> next cycle pending_cnt=0, busy=0; reset mid-stall -> stall_cycles=0.
